// File: rtl/fivexn_bit_unloader.sv
// fivexn_bit_unloader: accepts five words in one load handshake and streams them
// out word 0 first over valid/ready, chaining a new block onto the final beat.
module fivexn_bit_unloader #(
    parameter int width = 32,
    parameter logic [width-1:0] reset_value = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] in0,
    input  logic [width-1:0] in1,
    input  logic [width-1:0] in2,
    input  logic [width-1:0] in3,
    input  logic [width-1:0] in4,
    input  logic             load_valid,
    output logic             load_ready,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_index,
    output logic             out_last,
    output logic             busy
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [4:0][width-1:0] word_q, word_d;
    logic load_acc;
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        load_ready = state_q == IDLE || (idx_q == 3'd4 && out_ready);
        load_acc   = load_valid && load_ready;
        if (load_acc) begin
            state_d = STREAM;
            idx_d   = 3'd0;
            word_d  = {in4, in3, in2, in1, in0};
        end else if (state_q == STREAM && (idx_q > 3'd4 || (out_ready && idx_q == 3'd4))) begin
            state_d = IDLE;
            idx_d   = 3'd0;
        end else if (state_q == STREAM && out_ready) begin
            idx_d = idx_q + 3'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            word_q  <= {5{reset_value}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end
    // Out-of-range index encodings fall back to word 0 until the FSM recovers.
    assign out_data  = idx_q > 3'd4 ? word_q[0] : word_q[idx_q];
    assign out_valid = state_q == STREAM;
    assign busy      = state_q == STREAM;
    assign out_index = idx_q;
    assign out_last  = state_q == STREAM && idx_q == 3'd4;
endmodule

// File: tb/tb_fivexn_bit_unloader.sv
// tb_fivexn_bit_unloader: scoreboard-based bench; words queued at load, checked per accepted beat.
module tb_fivexn_bit_unloader;
    localparam logic [7:0] RV = 8'h5A;
    logic clk = 1'b0;
    logic reset, load_valid, out_ready;
    logic [7:0] in0, in1, in2, in3, in4;
    logic load_ready, out_valid, out_last, busy;
    logic [7:0] out_data;
    logic [2:0] out_index;
    typedef struct packed {logic [7:0] d; logic [2:0] i;} beat_t;
    beat_t sb[$];
    beat_t e;
    int tests = 0;
    int fails = 0;

    fivexn_bit_unloader #(.width(8), .reset_value(RV)) dut (
        .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .load_valid(load_valid), .load_ready(load_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_words(input logic [7:0] b);
        in0 = b; in1 = b + 8'd1; in2 = b + 8'd2; in3 = b + 8'd3; in4 = b + 8'd4;
    endtask

    task automatic push_block(input logic [7:0] b);
        for (int i = 0; i < 5; i++) sb.push_back('{d: b + 8'(i), i: 3'(i)});
    endtask

    task automatic test_reset();
        reset = 1'b0; load_valid = 1'b0; out_ready = 1'b0; set_words(8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tests++;
        if ({out_valid, out_last, busy, out_index, load_ready} !== 7'b000_0001 || out_data !== RV) begin
            fails++;
            $display("FAIL reset: valid=%b last=%b busy=%b idx=%0d ready=%b data=%h, required 0 0 0 0 1 %h",
                     out_valid, out_last, busy, out_index, load_ready, out_data, RV);
        end
    endtask

    task automatic test_single();
        set_words(8'hA0); load_valid = 1'b1; out_ready = 1'b1;
        tests++;
        if (load_ready !== 1'b1) begin fails++; $display("FAIL single_load_ready: got %b want 1", load_ready); end
        push_block(8'hA0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            load_valid = 1'b0; set_words(8'($urandom));
            tests++;
            e = sb.pop_front();
            if (out_valid !== 1'b1 || out_data !== e.d || out_index !== e.i || out_last !== (k == 4)) begin
                fails++;
                $display("FAIL single_beat%0d: v=%b d=%h i=%0d l=%b, required 1 %h %0d %b",
                         k, out_valid, out_data, out_index, out_last, e.d, e.i, k == 4);
            end
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_end: valid=%b ready=%b busy=%b, required 0 1 0", out_valid, load_ready, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        logic stall;
        int k;
        set_words(8'hA0); load_valid = 1'b1; out_ready = 1'b1;
        push_block(8'hA0);
        stall = 1'b0; held = 8'h00; k = 0;
        while (sb.size() != 0 && k < 30) begin
            @(negedge clk);
            load_valid = 1'b0; set_words(8'($urandom));
            out_ready = (k % 3) == 0;
            if (stall) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    fails++;
                    $display("FAIL bp_hold%0d: v=%b d=%h, required 1 %h", k, out_valid, out_data, held);
                end
            end
            if (out_ready) begin
                e = sb.pop_front();
                tests++;
                if (out_valid !== 1'b1 || out_data !== e.d || out_index !== e.i || out_last !== (e.i == 3'd4)) begin
                    fails++;
                    $display("FAIL bp_beat: v=%b d=%h i=%0d l=%b, required 1 %h %0d %b",
                             out_valid, out_data, out_index, out_last, e.d, e.i, e.i == 3'd4);
                end
            end
            stall = !out_ready; held = out_data;
            k++;
        end
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL bp_drain: %0d words left, required 0", sb.size()); end
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_end: valid=%b required 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        set_words(8'hA0); load_valid = 1'b1; out_ready = 1'b1;
        push_block(8'hA0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            load_valid = (k == 4);
            set_words(k == 4 ? 8'hB0 : 8'($urandom));
            tests++;
            if (load_ready !== (k == 4 || k == 9)) begin
                fails++;
                $display("FAIL b2b_ready%0d: got %b want %b", k, load_ready, k == 4 || k == 9);
            end
            if (k == 4) push_block(8'hB0);
            e = sb.pop_front();
            tests++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_index !== e.i || out_last !== (e.i == 3'd4)) begin
                fails++;
                $display("FAIL b2b_beat%0d: v=%b d=%h i=%0d l=%b, required 1 %h %0d %b",
                         k, out_valid, out_data, out_index, out_last, e.d, e.i, e.i == 3'd4);
            end
        end
        load_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: valid=%b required 0", out_valid); end
    endtask

    task automatic test_ignored_load();
        set_words(8'hA0); load_valid = 1'b1; out_ready = 1'b1;
        push_block(8'hA0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            load_valid = (k == 2);
            set_words(k == 2 ? 8'hC0 : 8'($urandom));
            if (k == 2) begin
                tests++;
                if (load_ready !== 1'b0) begin fails++; $display("FAIL ign_ready: got %b want 0", load_ready); end
            end
            e = sb.pop_front();
            tests++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_index !== e.i) begin
                fails++;
                $display("FAIL ign_beat%0d: v=%b d=%h i=%0d, required 1 %h %0d", k, out_valid, out_data, out_index, e.d, e.i);
            end
        end
        load_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL ign_end: valid=%b required 0", out_valid); end
    endtask

    task automatic test_reset_mid_stream();
        set_words(8'hA0); load_valid = 1'b1; out_ready = 1'b1;
        push_block(8'hA0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            load_valid = 1'b0; set_words(8'($urandom));
            out_ready = (k < 2);
            tests++;
            if (out_valid !== 1'b1 || out_data !== sb[0].d || out_index !== sb[0].i) begin
                fails++;
                $display("FAIL rst_pre%0d: v=%b d=%h i=%0d, required 1 %h %0d", k, out_valid, out_data, out_index, sb[0].d, sb[0].i);
            end
            if (out_ready) void'(sb.pop_front());
        end
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        tests++;
        if ({out_valid, busy, out_index, load_ready} !== 6'b00_0001 || out_data !== RV) begin
            fails++;
            $display("FAIL rst_mid: v=%b busy=%b i=%0d ready=%b d=%h, required 0 0 0 1 %h",
                     out_valid, busy, out_index, load_ready, out_data, RV);
        end
        set_words(8'hD0); load_valid = 1'b1;
        push_block(8'hD0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            e = sb.pop_front();
            tests++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_index !== e.i) begin
                fails++;
                $display("FAIL rst_after%0d: v=%b d=%h i=%0d, required 1 %h %0d", k, out_valid, out_data, out_index, e.d, e.i);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_ignored_load();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fivexn_bit_unloader.md
Name: fivexn_bit_unloader

Overview:
Parallel-in, serial-out companion to the five-word register bank. Accepts five width-bit words in one load handshake and streams them out one word per accepted beat, word 0 first, over a valid/ready interface. Sits at the read side of the five-word bank: the bank's five outputs feed in0..in4, and a narrow single-word datapath consumes the stream.

Parameters:
width, 32, bit width of each word
reset_value, 0, value loaded into all five internal word registers on reset

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
in0  input  width  word 0, emitted first
in1  input  width  word 1
in2  input  width  word 2
in3  input  width  word 3
in4  input  width  word 4, emitted last
load_valid  input  1  in0..in4 hold a block to accept
load_ready  output  1  block can accept a load this cycle
out_data  output  width  current stream word
out_valid  output  1  out_data/out_index/out_last are valid
out_ready  input  1  consumer accepts the current word
out_index  output  3  index 0..4 of the current word
out_last  output  1  high with word 4 (out_index==4 and out_valid)
busy  output  1  high in STREAM state

Behaviour:
- States: IDLE, STREAM. Five internal width-bit word registers plus a 3-bit index register.
- Reset (reset==0 at clk edge): state=IDLE, index=0, all word registers=reset_value. Outputs after reset: out_valid=0, out_last=0, busy=0, out_index=0, out_data=reset_value, load_ready=1. Reset overrides every other input in the same cycle.
- Reset mid-stream aborts the block. Remaining words are discarded and are never emitted.
- load_ready (combinational) = IDLE, or (STREAM and index==4 and out_ready).
- Load accept: load_valid and load_ready at an edge. Captures in0..in4, sets index=0 and state=STREAM.
- Load latency: out_valid=1 with word 0 in the cycle after the load is accepted.
- load_valid with load_ready==0 is ignored. No capture occurs and in0..in4 may change freely.
- STREAM: out_valid=1 and out_data=word[index]. out_data, out_index and out_last stay stable while out_ready==0, with no timeout.
- Beat accept: out_valid and out_ready at an edge.
  - index<4: index increments and the state stays STREAM.
  - index==4, no load accepted that edge: state=IDLE and index=0; out_valid=0 next cycle.
  - index==4, load accepted that edge: the new words are captured, index=0 and state stays STREAM. Word 0 of the new block follows the old word 4 with no bubble.
- out_valid=0 in IDLE. out_data in IDLE is word[0] of the last block (or reset_value) and is don't-care to the consumer.
- Word registers change only on load accept or on reset.
- Throughput: 5 words per 5 cycles with out_ready held high and back-to-back loads.
- index never exceeds 4. Encodings 5..7 are unreachable; if forced, the next edge goes to IDLE with index=0.

Test Plan:
- Reset, single block: reset=0 for 2 cycles, then load 0xA0..0xA4 with out_ready=1. Required: out_data 0xA0,0xA1,0xA2,0xA3,0xA4 on 5 consecutive cycles starting 1 cycle after load; out_index 0..4; out_last only with 0xA4; then out_valid=0 and load_ready=1.
- Backpressure: same block with out_ready toggling 1,0,0,1,... Required: each word held stable while out_ready=0; sequence 0xA0..0xA4 emitted exactly once each, in order.
- Back-to-back: load_valid held high with 0xB0..0xB4 presented during the final beat of block A. Required: 0xB0 appears the cycle after 0xA4 is accepted; load_ready=1 only during that final beat.
- Ignored load: while streaming block A at index 2, pulse load_valid with 0xC0..0xC4. Required: load_ready=0; the stream continues 0xA2,0xA3,0xA4 unaffected.
- Reset mid-stream: reset=0 at index 2. Required: next cycle out_valid=0, busy=0, out_data=reset_value (test with reset_value=0x5A), load_ready=1; the following load streams from index 0.
